// File: rtl/bcd_to_binary_serial_pkg.sv
// Shared types and helpers for the serial BCD-to-binary converter.
// Digits are 4-bit BCD; the converter FSM has two states.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } conv_state_t;

  function automatic logic is_bcd_digit(input bcd_digit_t d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_to_binary_serial_if.sv
// Request/result bundle between a BCD source and the serial converter.
// Handshake: a request is taken on a rising edge where start=1 and ready=1; done is a
// one-cycle pulse qualifying binary/err/ovf, which then hold until the next accepted start.
interface bcd_to_binary_serial_if #(
    parameter int NUM_DIGITS = 3,
    parameter int BIN_WIDTH  = 10
);
    logic                           start;
    logic [NUM_DIGITS-1:0][3:0]     bcd_in;
    logic                           ready;
    logic                           done;
    logic [BIN_WIDTH-1:0]           binary;
    logic                           err;
    logic                           ovf;

    modport master (
        output start, bcd_in,
        input  ready, done, binary, err, ovf
    );

    modport slave (
        input  start, bcd_in,
        output ready, done, binary, err, ovf
    );
endinterface

// File: rtl/bcd_to_binary_serial_digit_adj.sv
// One-digit correction step of reverse double-dabble: after a right shift,
// a digit that picked up the 8s bit from its upper neighbour is brought back to BCD.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  bcd_digit_t d_in,
    output bcd_digit_t d_out
);
    assign d_out = (d_in >= 4'd8) ? d_in - 4'd3 : d_in;
endmodule

// File: rtl/bcd_to_binary_serial.sv
// Serial BCD-to-binary converter using reverse double-dabble: BIN_WIDTH right shifts of
// {digits,binary}, each followed by a per-digit "subtract 3 if >= 8" correction.
module bcd_to_binary_serial
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int BIN_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_to_binary_serial_if.slave bus,
    output conv_state_t           dbgState
);
    localparam int CW = $clog2(BIN_WIDTH + 1);

    conv_state_t                state;
    logic [CW-1:0]              count;
    logic [NUM_DIGITS-1:0][3:0] digitReg;
    logic [NUM_DIGITS-1:0][3:0] shDigits;
    logic [NUM_DIGITS-1:0][3:0] adjDigits;
    logic [BIN_WIDTH-1:0]       binReg;
    logic [BIN_WIDTH-1:0]       shBin;
    logic                       errReg;
    logic                       ovfReg;
    logic                       doneReg;
    logic                       allValid;

    // Digit 0's LSB falls into the binary MSB; each digit's LSB lands in the 8s bit below it.
    assign {shDigits, shBin} = {digitReg, binReg} >> 1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : gAdj
        bcd_digit_adj uAdj (
            .d_in  (shDigits[i]),
            .d_out (adjDigits[i])
        );
    end

    always_comb begin
        allValid = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!is_bcd_digit(bus.bcd_in[i])) allValid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            digitReg <= '0;
            binReg   <= '0;
            errReg   <= 1'b0;
            ovfReg   <= 1'b0;
            doneReg  <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        binReg <= '0;
                        ovfReg <= 1'b0;
                        if (allValid) begin
                            digitReg <= bus.bcd_in;
                            count    <= CW'(BIN_WIDTH);
                            errReg   <= 1'b0;
                            state    <= SHIFT;
                        end else begin
                            // Bad digit: report immediately without running the shifter.
                            errReg  <= 1'b1;
                            doneReg <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    digitReg <= adjDigits;
                    binReg   <= shBin;
                    count    <= count - 1'b1;
                    if (count == CW'(1)) begin
                        // Anything left in the digits is the part that did not fit.
                        ovfReg  <= (adjDigits != '0);
                        doneReg <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready  = (state == IDLE);
    assign bus.done   = doneReg;
    assign bus.binary = binReg;
    assign bus.err    = errReg;
    assign bus.ovf    = ovfReg;
    assign dbgState   = state;

endmodule

// File: tb/tb_bcd_to_binary_serial.sv
// Directed bench for bcd_to_binary_serial: latency, results, error/overflow flags,
// ignored starts, async reset and a scoreboarded random sweep.
module tb_bcd_to_binary_serial;
  import bcd_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  conv_state_t dbg_state;
  conv_state_t dbg_state8;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [9:0]  exp_q[$];

  bcd_to_binary_serial_if #(.NUM_DIGITS(3), .BIN_WIDTH(10)) bus ();
  bcd_to_binary_serial_if #(.NUM_DIGITS(3), .BIN_WIDTH(8))  bus8 ();

  bcd_to_binary_serial #(.NUM_DIGITS(3), .BIN_WIDTH(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbgState (dbg_state)
  );

  bcd_to_binary_serial #(.NUM_DIGITS(3), .BIN_WIDTH(8)) dut8 (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus8),
    .dbgState (dbg_state8)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // driver tasks
  task automatic start_conv(input logic [11:0] bcd);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = bcd;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
  endtask

  // Counts edges from the accepting edge (=1) until done is seen, bounded.
  task automatic wait_done(output int edges);
    edges = 1;
    while (bus.done !== 1'b1 && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0;  bus.bcd_in = '0;
    bus8.start = 1'b0; bus8.bcd_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_checks++; if (bus.binary !== 10'd0) begin n_fail++; $display("FAIL reset_binary: got %0d want 0", bus.binary); end
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
    n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
  endtask

  task automatic test_max;
    int edges;
    start_conv(to_bcd(999));
    n_checks++; if (dbg_state !== SHIFT) begin n_fail++; $display("FAIL max_state: got %0d want SHIFT", dbg_state); end
    n_checks++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL max_busy: ready got %b want 0", bus.ready); end
    wait_done(edges);
    n_checks++; if (edges !== 11) begin n_fail++; $display("FAIL max_latency: got %0d edges want 11", edges); end
    n_checks++; if (bus.binary !== 10'h3E7) begin n_fail++; $display("FAIL max_binary: got %0d want 999", bus.binary); end
    n_checks++; if (bus.err !== 1'b0 || bus.ovf !== 1'b0) begin n_fail++; $display("FAIL max_flags: err=%b ovf=%b want 0 0", bus.err, bus.ovf); end
    n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL max_ready: got %b want 1", bus.ready); end
  endtask

  task automatic test_invalid;
    int edges;
    start_conv(12'h0A0);
    wait_done(edges);
    n_checks++; if (edges !== 1) begin n_fail++; $display("FAIL inv_latency: got %0d edges want 1", edges); end
    n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL inv_err: got %b want 1", bus.err); end
    n_checks++; if (bus.binary !== 10'd0) begin n_fail++; $display("FAIL inv_binary: got %0d want 0", bus.binary); end
    n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL inv_ready: got %b want 1", bus.ready); end
    n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL inv_ovf: got %b want 0", bus.ovf); end
    @(posedge clk);
    #1;
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL inv_pulse: done got %b want 0", bus.done); end
  endtask

  task automatic test_values;
    int vals[6] = '{255, 0, 100, 512, 87, 9};
    int edges;
    foreach (vals[i]) begin
      start_conv(to_bcd(vals[i]));
      wait_done(edges);
      n_checks++; if (edges !== 11) begin n_fail++; $display("FAIL val_latency[%0d]: got %0d want 11", vals[i], edges); end
      n_checks++; if (bus.binary !== 10'(vals[i])) begin n_fail++; $display("FAIL val_binary: got %0d want %0d", bus.binary, vals[i]); end
      n_checks++; if (bus.err !== 1'b0 || bus.ovf !== 1'b0) begin n_fail++; $display("FAIL val_flags[%0d]: err=%b ovf=%b want 0 0", vals[i], bus.err, bus.ovf); end
    end
  endtask

  task automatic test_back_to_back;
    int edges;
    start_conv(to_bcd(123));
    wait_done(edges);
    n_checks++; if (bus.binary !== 10'd123) begin n_fail++; $display("FAIL b2b_first: got %0d want 123", bus.binary); end
    start_conv(to_bcd(456));
    n_checks++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: ready got %b want 0", bus.ready); end
    wait_done(edges);
    n_checks++; if (edges !== 11) begin n_fail++; $display("FAIL b2b_latency: got %0d want 11", edges); end
    n_checks++; if (bus.binary !== 10'd456) begin n_fail++; $display("FAIL b2b_second: got %0d want 456", bus.binary); end
  endtask

  task automatic test_overflow;
    int edges;
    @(negedge clk);
    bus8.start  = 1'b1;
    bus8.bcd_in = to_bcd(999);
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    edges = 1;
    while (bus8.done !== 1'b1 && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    n_checks++; if (edges !== 9) begin n_fail++; $display("FAIL ovf_latency: got %0d edges want 9", edges); end
    n_checks++; if (bus8.binary !== 8'd231) begin n_fail++; $display("FAIL ovf_binary: got %0d want 231", bus8.binary); end
    n_checks++; if (bus8.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", bus8.ovf); end
    n_checks++; if (bus8.err !== 1'b0) begin n_fail++; $display("FAIL ovf_err: got %b want 0", bus8.err); end
  endtask

  task automatic test_ignored_start;
    int edges;
    start_conv(to_bcd(321));
    edges = 1;
    while (bus.done !== 1'b1 && edges < 40) begin
      if (edges == 3) begin
        bus.start  = 1'b1;
        bus.bcd_in = to_bcd(777);
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      edges++;
    end
    n_checks++; if (edges !== 11) begin n_fail++; $display("FAIL ign_latency: got %0d want 11", edges); end
    n_checks++; if (bus.binary !== 10'd321) begin n_fail++; $display("FAIL ign_binary: got %0d want 321", bus.binary); end
    @(posedge clk);
    #1;
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL ign_no_second: done got %b want 0", bus.done); end
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (bus.binary !== 10'd321) begin n_fail++; $display("FAIL ign_hold: got %0d want 321", bus.binary); end
    n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL ign_ready: got %b want 1", bus.ready); end
  endtask

  task automatic test_reset_mid;
    int  edges;
    bit  seen_done;
    start_conv(to_bcd(888));
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (dbg_state !== SHIFT) begin n_fail++; $display("FAIL rmid_shifting: got %0d want SHIFT", dbg_state); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", bus.ready); end
    n_checks++; if (bus.binary !== 10'd0) begin n_fail++; $display("FAIL rmid_binary: got %0d want 0", bus.binary); end
    n_checks++; if (bus.done !== 1'b0 || bus.err !== 1'b0 || bus.ovf !== 1'b0) begin n_fail++; $display("FAIL rmid_flags: done=%b err=%b ovf=%b want 0 0 0", bus.done, bus.err, bus.ovf); end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL rmid_no_done: got %b want 0", seen_done); end
    start_conv(to_bcd(64));
    wait_done(edges);
    n_checks++; if (edges !== 11) begin n_fail++; $display("FAIL rmid_after_latency: got %0d want 11", edges); end
    n_checks++; if (bus.binary !== 10'd64) begin n_fail++; $display("FAIL rmid_after_binary: got %0d want 64", bus.binary); end
  endtask

  // scoreboard-driven random sweep; previous result from test_reset_mid is 64
  task automatic test_random;
    int         v;
    int         gap;
    int         edges;
    logic [9:0] exp;
    logic [9:0] last_exp;
    last_exp = 10'd64;
    for (int i = 0; i < 30; i++) begin
      v   = $urandom_range(0, 999);
      gap = $urandom_range(0, 3);
      exp_q.push_back(10'(v));
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
        n_checks++; if (bus.binary !== last_exp) begin n_fail++; $display("FAIL rnd_hold: got %0d want %0d", bus.binary, last_exp); end
      end
      start_conv(to_bcd(v));
      wait_done(edges);
      exp = exp_q.pop_front();
      n_checks++; if (edges !== 11) begin n_fail++; $display("FAIL rnd_spacing: got %0d want 11", edges); end
      n_checks++; if (bus.binary !== exp) begin n_fail++; $display("FAIL rnd_binary: got %0d want %0d", bus.binary, exp); end
      n_checks++; if (bus.err !== 1'b0 || bus.ovf !== 1'b0) begin n_fail++; $display("FAIL rnd_flags: err=%b ovf=%b want 0 0", bus.err, bus.ovf); end
      last_exp = exp;
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_invalid();
    test_values();
    test_back_to_back();
    test_overflow();
    test_ignored_start();
    test_reset_mid();
    test_random();
    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
